// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter: owner/state encoding.
package dmem_arbiter_pkg;
  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  function automatic logic is_owner(input state_t own, input state_t who);
    return own == who;
  endfunction
endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins) and async reset.
module sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt
);
  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                   r_cnt <= '0;
    else if (i_clr)                              r_cnt <= '0;
    else if (i_inc && r_cnt != WIDTH'(MAX))      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU priority, starvation escape for DMA,
// bounded DMA lock bursts. Grant is combinational; owner is registered.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DATA_BUS_WIDTH = 17,
  parameter int STARVE_LIMIT   = 4,
  parameter int MAX_BURST      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_read,
  input  logic                      cpu_write,
  input  logic [DATA_BUS_WIDTH-1:0] cpu_adr,
  input  logic [DATA_WIDTH-1:0]     cpu_wd,
  output logic [DATA_WIDTH-1:0]     cpu_rd,
  output logic                      cpu_stall,
  input  logic                      dma_req,
  input  logic                      dma_we,
  input  logic                      dma_lock,
  input  logic [DATA_BUS_WIDTH-1:0] dma_adr,
  input  logic [DATA_WIDTH-1:0]     dma_wd,
  output logic                      dma_gnt,
  output logic [DATA_WIDTH-1:0]     dma_rd,
  output logic                      dma_valid,
  output logic                      mem_we,
  output logic [DATA_BUS_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0]     mem_wd,
  input  logic [DATA_WIDTH-1:0]     mem_rd
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t                r_state;
  state_t                w_owner;
  logic [SW-1:0]         w_streak;
  logic [BW-1:0]         w_burst;
  logic                  w_cpu_req, w_gnt_cpu, w_gnt_dma, w_in_dma, w_rule_a;
  logic [DATA_WIDTH-1:0] r_dma_rd;
  logic                  r_dma_valid;

  assign w_cpu_req = cpu_read | cpu_write;
  assign w_in_dma  = (r_state == ST_DMA);
  assign w_rule_a  = w_in_dma & dma_req & dma_lock & (w_burst < BW'(MAX_BURST));

  // Reset gates every grant so nothing reaches the RAM while it is held.
  always_comb begin
    w_owner = ST_IDLE;
    if (!reset) begin
      if (w_rule_a)                                             w_owner = ST_DMA;
      else if (w_cpu_req && dma_req && w_streak == SW'(STARVE_LIMIT)) w_owner = ST_DMA;
      else if (w_cpu_req)                                       w_owner = ST_CPU;
      else if (dma_req)                                         w_owner = ST_DMA;
    end
  end

  assign w_gnt_cpu = is_owner(w_owner, ST_CPU);
  assign w_gnt_dma = is_owner(w_owner, ST_DMA);

  sat_counter #(.WIDTH(SW), .MAX(STARVE_LIMIT)) u_streak (
    .i_clk (clk),
    .i_rst (reset),
    .i_inc (w_gnt_cpu & dma_req),
    .i_clr (w_gnt_dma | ~dma_req),
    .o_cnt (w_streak)
  );

  // Burst count restarts on both entry to and exit from DMA ownership.
  sat_counter #(.WIDTH(BW), .MAX(MAX_BURST)) u_burst (
    .i_clk (clk),
    .i_rst (reset),
    .i_inc (w_rule_a & w_cpu_req),
    .i_clr (w_gnt_dma ^ w_in_dma),
    .o_cnt (w_burst)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_dma_rd    <= '0;
      r_dma_valid <= 1'b0;
    end else begin
      r_state     <= w_owner;
      r_dma_valid <= w_gnt_dma & ~dma_we;
      if (w_gnt_dma && !dma_we) r_dma_rd <= mem_rd;
    end
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    if (w_gnt_cpu) begin
      mem_we  = cpu_write;
      mem_adr = cpu_adr;
      mem_wd  = cpu_wd;
    end else if (w_gnt_dma) begin
      mem_we  = dma_we;
      mem_adr = dma_adr;
      mem_wd  = dma_wd;
    end
  end

  assign cpu_rd    = mem_rd;
  assign cpu_stall = w_cpu_req & ~w_gnt_cpu & ~reset;
  assign dma_gnt   = dma_req & w_gnt_dma;
  assign dma_rd    = r_dma_rd;
  assign dma_valid = r_dma_valid;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port data RAM.
module tb_dmem_arbiter;
  localparam int DW  = 32;
  localparam int DBW = 17;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_read, cpu_write, dma_req, dma_we, dma_lock;
  logic [DBW-1:0] cpu_adr, dma_adr, mem_adr;
  logic [DW-1:0]  cpu_wd, cpu_rd, dma_wd, dma_rd, mem_wd, mem_rd;
  logic           cpu_stall, dma_gnt, dma_valid, mem_we;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] ram [0:(1<<DBW)-1];

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_adr] <= mem_wd;
  assign mem_rd = ram[mem_adr];

  dmem_arbiter #(.DATA_WIDTH(DW), .DATA_BUS_WIDTH(DBW), .STARVE_LIMIT(4), .MAX_BURST(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_adr(dma_adr),
    .dma_wd(dma_wd), .dma_gnt(dma_gnt), .dma_rd(dma_rd), .dma_valid(dma_valid),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_read = 0; cpu_write = 0; cpu_adr = '0; cpu_wd = '0;
    dma_req = 0; dma_we = 0; dma_lock = 0; dma_adr = '0; dma_wd = '0;
  endtask

  // Grant pattern for the locked burst: cycle 0 DMA alone, CPU waiting from cycle 1.
  logic [14:0] burst_exp_dma;

  initial begin
    foreach (ram[i]) ram[i] = '0;
    idle_inputs();
    reset = 1'b1;

    // CPU write attempted while reset is held must not reach the RAM
    cpu_write = 1; cpu_adr = 17'h50; cpu_wd = 32'h1;
    #2;
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_we", mem_we, 1'b0);
    tick(); tick();
    check("rst_nowrite", ram[17'h50], 32'h0);
    idle_inputs();
    reset = 1'b0;
    #2;
    check("rst_valid", dma_valid, 1'b0);
    check("rst_dma_rd", dma_rd, 32'h0);
    tick();

    // CPU only
    cpu_write = 1; cpu_adr = 17'h10; cpu_wd = 32'hDEADBEEF;
    #2;
    check("cpu_wr_stall", cpu_stall, 1'b0);
    check("cpu_wr_we", mem_we, 1'b1);
    check("cpu_wr_adr", 32'(mem_adr), 32'h10);
    tick();
    cpu_write = 0; cpu_read = 1;
    #2;
    check("cpu_rd_data", cpu_rd, 32'hDEADBEEF);
    check("cpu_rd_we", mem_we, 1'b0);
    tick();
    idle_inputs();
    #2;
    check("idle_adr", 32'(mem_adr), 32'h0);
    check("idle_wd", mem_wd, 32'h0);
    check("idle_we", mem_we, 1'b0);
    tick();

    // DMA only
    dma_req = 1; dma_we = 1; dma_adr = 17'h20; dma_wd = 32'h12345678;
    #2;
    check("dma_wr_gnt", dma_gnt, 1'b1);
    check("dma_wr_we", mem_we, 1'b1);
    check("dma_wr_adr", 32'(mem_adr), 32'h20);
    tick();
    dma_we = 0;
    #2;
    check("dma_rd_gnt", dma_gnt, 1'b1);
    check("dma_rd_we", mem_we, 1'b0);
    tick();
    idle_inputs();
    #2;
    check("dma_valid_hi", dma_valid, 1'b1);
    check("dma_rd_data", dma_rd, 32'h12345678);
    tick();
    #2;
    check("dma_valid_lo", dma_valid, 1'b0);
    tick();

    // Continuous contention without lock: C,C,C,C,D repeating
    cpu_read = 1; cpu_adr = 17'h10; dma_req = 1; dma_adr = 17'h20;
    for (int i = 0; i < 10; i++) begin
      #2;
      check($sformatf("starve_gnt%0d", i), dma_gnt, (i % 5) == 4);
      check($sformatf("starve_stall%0d", i), cpu_stall, (i % 5) == 4);
      tick();
    end
    idle_inputs();
    tick();

    // Locked burst: DMA x9 (entry + 8 locked), CPU x4, DMA re-acquires via starvation
    burst_exp_dma = 15'b110_0001_1111_1111;
    dma_req = 1; dma_lock = 1; dma_adr = 17'h20; cpu_adr = 17'h10;
    for (int i = 0; i < 15; i++) begin
      cpu_read = (i >= 1);
      #2;
      check($sformatf("burst_gnt%0d", i), dma_gnt, burst_exp_dma[i]);
      check($sformatf("burst_stall%0d", i), cpu_stall, cpu_read & burst_exp_dma[i]);
      tick();
    end
    idle_inputs();
    tick();

    // Read+write together with DMA idle behaves as a write
    cpu_read = 1; cpu_write = 1; cpu_adr = 17'h30; cpu_wd = 32'hA5A5A5A5;
    #2;
    check("rw_we", mem_we, 1'b1);
    check("rw_stall", cpu_stall, 1'b0);
    check("rw_adr", 32'(mem_adr), 32'h30);
    tick();
    cpu_write = 0;
    #2;
    check("rw_readback", cpu_rd, 32'hA5A5A5A5);
    tick();
    idle_inputs();
    tick();

    // Reset in the middle of a locked DMA write burst
    dma_req = 1; dma_lock = 1; dma_we = 1; dma_adr = 17'h40; dma_wd = 32'h77;
    tick();
    cpu_write = 1; cpu_adr = 17'h44; cpu_wd = 32'h99;
    #2;
    check("mid_gnt_pre", dma_gnt, 1'b1);
    check("mid_stall_pre", cpu_stall, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_gnt_rst", dma_gnt, 1'b0);
    check("mid_we_rst", mem_we, 1'b0);
    check("mid_stall_rst", cpu_stall, 1'b0);
    tick();
    reset = 1'b0;
    #2;
    // Back in IDLE with cleared counters: CPU wins over the still-locked DMA
    check("post_gnt", dma_gnt, 1'b0);
    check("post_stall", cpu_stall, 1'b0);
    check("post_adr", 32'(mem_adr), 32'h44);
    check("post_valid", dma_valid, 1'b0);
    check("post_nowrite", ram[17'h44], 32'h0);
    tick();
    idle_inputs();
    #2;
    check("post_cpu_write", ram[17'h44], 32'h99);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
